// File: rtl/key_pkg.sv
// Shared key-event types, scancode constants and the game-key map.
package key_pkg;

    localparam int unsigned NKEYS = 8;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    typedef enum logic [2:0] {
        K_LEFT  = 3'd0,
        K_RIGHT = 3'd1,
        K_UP    = 3'd2,
        K_SPACE = 3'd3,
        K_ENTER = 3'd4,
        K_ESC   = 3'd5,
        K_P     = 3'd6,
        K_DOWN  = 3'd7
    } key_idx_e;

    typedef struct packed {
        logic       make;
        logic       ext;
        logic [7:0] code;
    } key_evt_t;

    typedef struct packed {
        logic     hit;
        key_idx_e idx;
    } key_hit_t;

    // Maps {ext, code} to a game key slot; hit=0 for keys the game ignores.
    function automatic key_hit_t key_map(input logic [8:0] ext_code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = K_LEFT;
        case (ext_code)
            9'h16B:  r.idx = K_LEFT;
            9'h174:  r.idx = K_RIGHT;
            9'h175:  r.idx = K_UP;
            9'h029:  r.idx = K_SPACE;
            9'h05A:  r.idx = K_ENTER;
            9'h076:  r.idx = K_ESC;
            9'h04D:  r.idx = K_P;
            9'h172:  r.idx = K_DOWN;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for key events.
// A push while full is accepted only if a pop happens on the same edge.
module key_evt_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = key_pkg::key_evt_t
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           do_pop;
    logic           do_push;

    // Status flags, guarded push/pop and the fall-through head word.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (AW+1)'(DEPTH));
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        dout    = '0;
        if (!empty) begin
            dout = mem[rd_ptr_q];
        end
    end

    assign count = count_q;

    // Pointers wrap naturally; occupancy is tracked in its own counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: stale entries are never visible once empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Turns decoder scancodes into make/break events, a held-key bitmap and a fire pulse.
module key_event_ctrl #(
    parameter int DEPTH = 8,
    parameter int NKEYS = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            keyb_char,
    input  logic                   kbd_en,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [9:0]             evt_data,
    output logic [NKEYS-1:0]       key_down,
    output logic                   fire_pulse,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    import key_pkg::*;

    logic [31:0] kc_q;
    logic        is_new;
    logic        cls_valid;
    logic        cls_make;
    logic        cls_ext;
    logic        evt_push;
    logic        evt_pop;
    logic        evt_drop;
    logic        fifo_full;
    logic        fifo_empty;
    key_hit_t    hit;
    key_evt_t    evt_in;
    key_evt_t    evt_head;

    // Decode the scancode shape; prefix bytes in the low byte are not key codes.
    always_comb begin
        cls_valid = 1'b0;
        cls_make  = 1'b0;
        cls_ext   = 1'b0;
        if (keyb_char[31:24] == 8'h00 && keyb_char[7:0] != SC_E0 && keyb_char[7:0] != SC_F0) begin
            case (keyb_char[23:8])
                16'h0000:         begin cls_valid = 1'b1; cls_make = 1'b1;                  end
                {8'h00, SC_E0}:   begin cls_valid = 1'b1; cls_make = 1'b1; cls_ext = 1'b1; end
                {8'h00, SC_F0}:   begin cls_valid = 1'b1;                                  end
                {SC_E0, SC_F0}:   begin cls_valid = 1'b1;                  cls_ext = 1'b1; end
                default:          ;
            endcase
        end
    end

    // Typematic repeats leave keyb_char unchanged and so never look new.
    assign is_new   = kbd_en & (keyb_char != kc_q);
    assign evt_push = is_new & cls_valid;
    assign hit      = key_map({cls_ext, keyb_char[7:0]});
    assign evt_in   = '{make: cls_make, ext: cls_ext, code: keyb_char[7:0]};
    assign evt_pop  = evt_valid & evt_ready;
    assign evt_drop = evt_push & fifo_full & ~evt_pop;

    key_evt_fifo #(
        .DEPTH (DEPTH),
        .T     (key_evt_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (evt_push),
        .pop     (evt_ready),
        .din     (evt_in),
        .dout    (evt_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (evt_count)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_data  = evt_head;

    // Last-seen scancode, held-key bitmap, fire pulse and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kc_q       <= '0;
            key_down   <= '0;
            fire_pulse <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            kc_q       <= keyb_char;
            fire_pulse <= evt_push & cls_make & ~cls_ext & (keyb_char[7:0] == 8'h29);
            if (!kbd_en) begin
                key_down <= '0;
            end else if (evt_push && hit.hit) begin
                key_down[hit.idx] <= cls_make;
            end
            if (evt_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios plus randomized traffic vs. a queue model.
module tb_key_event_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] keyb_char;
    logic        kbd_en;
    logic        evt_valid;
    logic        evt_ready;
    logic [9:0]  evt_data;
    logic [7:0]  key_down;
    logic        fire_pulse;
    logic [3:0]  evt_count;
    logic        overflow;
    logic        ovf_clr;

    key_event_ctrl #(.DEPTH(DEPTH), .NKEYS(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .keyb_char  (keyb_char),
        .kbd_en     (kbd_en),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .key_down   (key_down),
        .fire_pulse (fire_pulse),
        .evt_count  (evt_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model state
    int unsigned m_q[$];
    logic [31:0] m_prev;
    logic [7:0]  m_keys;
    bit          m_ovf;
    bit          m_fire;

    int n_vec = 0;
    int n_err = 0;

    int key_codes[8] = '{'h16B, 'h174, 'h175, 'h029, 'h05A, 'h076, 'h04D, 'h172};

    function automatic int key_index(input int ec);
        for (int i = 0; i < 8; i++) begin
            if (key_codes[i] == ec) return i;
        end
        return -1;
    endfunction

    // Returns 1 for a reportable scancode, with make flag and {ext,code}.
    function automatic bit classify(input logic [31:0] c, output bit mk, output int ec);
        int unsigned prefix = c >> 8;
        int unsigned low    = c & 32'hFF;
        mk = 0;
        ec = 0;
        if (low == 'hE0 || low == 'hF0) return 0;
        if (prefix == 'h0000)      begin mk = 1; ec = low;         return 1; end
        if (prefix == 'h00E0)      begin mk = 1; ec = 'h100 + low; return 1; end
        if (prefix == 'h00F0)      begin mk = 0; ec = low;         return 1; end
        if (prefix == 'hE0F0)      begin mk = 0; ec = 'h100 + low; return 1; end
        return 0;
    endfunction

    function automatic int unsigned exp_data();
        return (m_q.size() > 0) ? m_q[0] : 0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_prev = '0;
        m_keys = '0;
        m_ovf  = 0;
        m_fire = 0;
    endtask

    // Apply one cycle of inputs, advance the model across the edge, settle 1 time unit.
    task automatic step(input logic [31:0] kc, input bit en, input bit rdy, input bit clr);
        bit mk;
        int ec;
        bit ok;
        bit ev;
        bit pop_now;
        bit dropped;
        int k;
        keyb_char = kc;
        kbd_en    = en;
        evt_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        pop_now = rdy && (m_q.size() > 0);
        ok      = classify(kc, mk, ec);
        ev      = en && (kc != m_prev) && ok;
        m_prev  = kc;
        dropped = 0;
        if (pop_now) void'(m_q.pop_front());
        if (ev) begin
            if (m_q.size() < DEPTH) m_q.push_back((int'(mk) << 9) | ec);
            else dropped = 1;
        end
        if (dropped) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (!en) m_keys = '0;
        else if (ev) begin
            k = key_index(ec);
            if (k >= 0) m_keys[k] = mk;
        end
        m_fire = ev && mk && (ec == 'h029);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        keyb_char = '0;
        kbd_en    = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        #12;
        n_vec++;
        if ({evt_valid, evt_data, key_down, fire_pulse, evt_count, overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_state got valid=%b data=%h keys=%h fire=%b cnt=%0d ovf=%b want all 0",
                     evt_valid, evt_data, key_down, fire_pulse, evt_count, overflow);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #4;
    endtask

    task automatic test_space_make();
        step(32'h0000_0029, 1, 0, 0);
        n_vec++;
        if (evt_data !== 10'h229 || key_down[3] !== 1'b1 || fire_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL space_make got data=%h key3=%b fire=%b want 229 1 1",
                     evt_data, key_down[3], fire_pulse);
        end
        step(32'h0000_0029, 1, 0, 0);
        n_vec++;
        if (fire_pulse !== 1'b0 || evt_count !== 4'd1) begin
            n_err++;
            $display("FAIL space_repeat got fire=%b cnt=%0d want 0 1", fire_pulse, evt_count);
        end
        step(32'h0000_F029, 1, 1, 0);
        n_vec++;
        if (evt_data !== 10'h029 || key_down[3] !== 1'b0 || evt_count !== 4'd1) begin
            n_err++;
            $display("FAIL space_break got data=%h key3=%b cnt=%0d want 029 0 1",
                     evt_data, key_down[3], evt_count);
        end
        step(32'h0000_F029, 1, 1, 0);
        n_vec++;
        if (evt_valid !== 1'b0 || evt_data !== 10'h000) begin
            n_err++;
            $display("FAIL drain_empty got valid=%b data=%h want 0 000", evt_valid, evt_data);
        end
    endtask

    task automatic test_ext_make_break();
        step(32'h0000_E06B, 1, 0, 0);
        n_vec++;
        if (key_down[0] !== 1'b1) begin
            n_err++;
            $display("FAIL left_make got key0=%b want 1", key_down[0]);
        end
        step(32'h00E0_F06B, 1, 0, 0);
        n_vec++;
        if (key_down[0] !== 1'b0 || evt_data !== 10'h36B || evt_count !== 4'd2) begin
            n_err++;
            $display("FAIL left_break got key0=%b head=%h cnt=%0d want 0 36b 2",
                     key_down[0], evt_data, evt_count);
        end
        step(32'h00E0_F06B, 1, 1, 0);
        n_vec++;
        if (evt_data !== 10'h16B) begin
            n_err++;
            $display("FAIL ext_order got head=%h want 16b", evt_data);
        end
        step(32'h00E0_F06B, 1, 1, 0);
        n_vec++;
        if (evt_count !== 4'd0) begin
            n_err++;
            $display("FAIL ext_drain got cnt=%0d want 0", evt_count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            step(32'h10 + i, 1, 0, 0);
            if (i == 7) begin
                n_vec++;
                if (evt_count !== 4'd8 || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_8 got cnt=%0d ovf=%b want 8 0", evt_count, overflow);
                end
            end
        end
        n_vec++;
        if (evt_count !== 4'd8 || overflow !== 1'b1 || evt_data !== 10'h210) begin
            n_err++;
            $display("FAIL overflow got cnt=%0d ovf=%b head=%h want 8 1 210",
                     evt_count, overflow, evt_data);
        end
        step(32'h18, 1, 1, 0);
        n_vec++;
        if (evt_count !== 4'd7 || evt_data !== 10'h211 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL first_pop got cnt=%0d head=%h ovf=%b want 7 211 1",
                     evt_count, evt_data, overflow);
        end
        step(32'h18, 1, 0, 1);
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clr got ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [9:0] last_head;
        step(32'h19, 1, 0, 0);
        step(32'h1A, 1, 1, 0);
        n_vec++;
        if (evt_count !== 4'd8 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_push_pop got cnt=%0d ovf=%b want 8 0", evt_count, overflow);
        end
        last_head = '0;
        for (int i = 0; i < 8; i++) begin
            last_head = evt_data;
            step(32'h1A, 1, 1, 0);
        end
        n_vec++;
        if (last_head !== 10'h21A || evt_count !== 4'd0) begin
            n_err++;
            $display("FAIL tail_entry got last=%h cnt=%0d want 21a 0", last_head, evt_count);
        end
    endtask

    task automatic test_disable();
        step(32'h0000_E075, 1, 0, 0);
        n_vec++;
        if (key_down[2] !== 1'b1) begin
            n_err++;
            $display("FAIL up_held got key2=%b want 1", key_down[2]);
        end
        step(32'h0000_E075, 0, 0, 0);
        n_vec++;
        if (key_down !== 8'h00 || evt_count !== 4'd1) begin
            n_err++;
            $display("FAIL disable_keys got keys=%h cnt=%0d want 00 1", key_down, evt_count);
        end
        step(32'h0000_005A, 0, 0, 0);
        step(32'h0000_005A, 1, 0, 0);
        n_vec++;
        if (evt_count !== 4'd1 || key_down !== 8'h00) begin
            n_err++;
            $display("FAIL disabled_change got cnt=%0d keys=%h want 1 00", evt_count, key_down);
        end
        step(32'h0000_005A, 0, 1, 0);
        n_vec++;
        if (evt_count !== 4'd0) begin
            n_err++;
            $display("FAIL disabled_pop got cnt=%0d want 0", evt_count);
        end
    endtask

    task automatic test_async_reset();
        step(32'h21, 1, 0, 0);
        step(32'h22, 1, 0, 0);
        step(32'h23, 1, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (evt_valid !== 1'b0 || evt_count !== 4'd0 || evt_data !== 10'h000) begin
            n_err++;
            $display("FAIL async_reset got valid=%b cnt=%0d data=%h want 0 0 000",
                     evt_valid, evt_count, evt_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #4;
        step(32'h1234_0029, 1, 0, 0);
        n_vec++;
        if (evt_count !== 4'd0 || key_down !== 8'h00 || fire_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL bad_byte3 got cnt=%0d keys=%h fire=%b want 0 00 0",
                     evt_count, key_down, fire_pulse);
        end
    endtask

    task automatic test_random();
        logic [31:0] kc;
        logic [31:0] prev_kc;
        int          r;
        int          low;
        prev_kc = 32'h1234_0029;
        for (int n = 0; n < 600; n++) begin
            r   = $urandom_range(0, 9);
            low = ($urandom_range(0, 1) == 1) ? key_codes[$urandom_range(0, 7)]
                                              : $urandom_range(0, 511);
            case (r)
                0, 1, 2, 3: kc = ((low & 'h100) != 0) ? (32'h0000_E000 | (low & 'hFF))
                                                      : (low & 'hFF);
                4, 5, 6, 7: kc = ((low & 'h100) != 0) ? (32'h00E0_F000 | (low & 'hFF))
                                                      : (32'h0000_F000 | (low & 'hFF));
                8:          kc = $urandom();
                default:    kc = prev_kc;
            endcase
            prev_kc = kc;
            step(kc, ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0));
            n_vec++;
            if (evt_valid !== (m_q.size() > 0) || evt_data !== 10'(exp_data())
                || evt_count !== 4'(m_q.size()) || key_down !== m_keys
                || fire_pulse !== m_fire || overflow !== m_ovf) begin
                n_err++;
                $display("FAIL random[%0d] got v=%b d=%h c=%0d k=%h f=%b o=%b want v=%b d=%h c=%0d k=%h f=%b o=%b",
                         n, evt_valid, evt_data, evt_count, key_down, fire_pulse, overflow,
                         (m_q.size() > 0), 10'(exp_data()), m_q.size(), m_keys, m_fire, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_space_make();
        test_ext_make_break();
        test_overflow();
        test_full_push_pop();
        test_disable();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
